// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the round-robin UART transmit scheduler.
package uart_sched_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        ACCEPT
    } state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set request at or after ptr, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int unsigned        nreq);
        rr_pick_t    pick;
        int unsigned j;
        pick = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= nreq) begin
                j = j - nreq;
            end
            if (k < nreq && !pick.found && req[j[IDX_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = j[IDX_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus index of the winner.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_enable,
    output logic [NREQ-1:0]  o_grant_c,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_valid_c
);

    rr_pick_t w_pick;

    assign w_pick    = rr_pick(MAX_REQ'(i_req), i_ptr, NREQ);
    assign o_valid_c = i_enable && w_pick.found;
    assign o_idx_c   = w_pick.idx;
    assign o_grant_c = o_valid_c ? (NREQ'(1) << w_pick.idx) : '0;

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between NREQ byte producers: grant, write strobe,
// wait for the UART to take the byte (or time out), then acknowledge.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WR_LEN  = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk16x,
    input  logic                   clr,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*BYTE_W-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic                   ack_err,
    output logic [BYTE_W-1:0]      uart_d_in,
    output logic                   uart_wrn,
    input  logic                   uart_t_empty,
    input  logic                   uart_sending,
    output logic                   busy,
    output logic                   err_sticky
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic [IDX_W-1:0]    r_idx, w_idx_nx;
    logic [IDX_W-1:0]    r_ptr, w_ptr_nx;
    logic [NREQ-1:0]     r_sel, w_sel_nx;
    logic [BYTE_W-1:0]   r_d_in, w_d_nx;
    logic                r_wrn, w_wrn_nx;
    logic [NREQ-1:0]     r_ack, w_ack_nx;
    logic                r_ack_err, w_ack_err_nx;
    logic                r_busy, w_busy_nx;
    logic                r_err, w_err_nx;

    logic [NREQ-1:0]     w_gnt;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_gnt_valid;
    logic [BYTE_W-1:0]   w_gnt_byte;
    logic [IDX_W-1:0]    w_ptr_inc;
    logic                w_taken;

    // No arbitration on the ack cycle, so the served requester cannot win again.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req     (req),
        .i_ptr     (r_ptr),
        .i_enable  ((r_state == IDLE) && uart_t_empty && (r_ack == '0)),
        .o_grant_c (w_gnt),
        .o_idx_c   (w_gnt_idx),
        .o_valid_c (w_gnt_valid)
    );

    always_comb begin
        w_gnt_byte = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_gnt_byte = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign w_ptr_inc = (r_idx == IDX_W'(NREQ - 1)) ? '0 : r_idx + IDX_W'(1);
    assign w_taken   = !uart_t_empty || uart_sending;

    always_ff @(posedge clk16x) begin
        if (clr) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_d_in    <= '0;
            r_wrn     <= 1'b1;
            r_ack     <= '0;
            r_ack_err <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_idx     <= w_idx_nx;
            r_ptr     <= w_ptr_nx;
            r_sel     <= w_sel_nx;
            r_d_in    <= w_d_nx;
            r_wrn     <= w_wrn_nx;
            r_ack     <= w_ack_nx;
            r_ack_err <= w_ack_err_nx;
            r_busy    <= w_busy_nx;
            r_err     <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_idx_nx     = r_idx;
        w_ptr_nx     = r_ptr;
        w_sel_nx     = r_sel;
        w_d_nx       = r_d_in;
        w_wrn_nx     = 1'b1;
        w_ack_nx     = '0;
        w_ack_err_nx = 1'b0;
        w_err_nx     = r_err;
        w_busy_nx    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_state_nx = WRITE;
                    w_idx_nx   = w_gnt_idx;
                    w_sel_nx   = w_gnt;
                    w_d_nx     = w_gnt_byte;
                    w_wrn_nx   = 1'b0;
                    w_cnt_nx   = '0;
                end
            end
            WRITE: begin
                w_wrn_nx = 1'b0;
                if (r_cnt == CNT_W'(WR_LEN - 1)) begin
                    w_state_nx = ACCEPT;
                    w_wrn_nx   = 1'b1;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            ACCEPT: begin
                // A taken byte wins over a timeout landing on the same cycle.
                if (w_taken || (r_cnt == CNT_W'(TIMEOUT - 1))) begin
                    w_state_nx   = IDLE;
                    w_ack_nx     = r_sel;
                    w_ack_err_nx = !w_taken;
                    w_err_nx     = r_err || !w_taken;
                    w_ptr_nx     = w_ptr_inc;
                    w_cnt_nx     = '0;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nx = IDLE;
        endcase

        w_busy_nx = (w_state_nx != IDLE);
    end

    assign ack        = r_ack;
    assign ack_err    = r_ack_err;
    assign uart_d_in  = r_d_in;
    assign uart_wrn   = r_wrn;
    assign busy       = r_busy;
    assign err_sticky = r_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: transaction-timing reference model, per-cycle compare,
// directed scenarios and a randomized phase with a reactive UART responder.
module tb_uart_tx_sched;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned WR_LEN  = 2;
    localparam int unsigned TIMEOUT = 64;

    logic              clk16x = 1'b0;
    logic              clr;
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic              ack_err;
    logic [7:0]        uart_d_in;
    logic              uart_wrn;
    logic              uart_t_empty;
    logic              uart_sending;
    logic              busy;
    logic              err_sticky;

    always #5 clk16x = ~clk16x;

    uart_tx_sched #(.NREQ(NREQ), .WR_LEN(WR_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk16x       (clk16x),
        .clr          (clr),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .ack_err      (ack_err),
        .uart_d_in    (uart_d_in),
        .uart_wrn     (uart_wrn),
        .uart_t_empty (uart_t_empty),
        .uart_sending (uart_sending),
        .busy         (busy),
        .err_sticky   (err_sticky)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Reference model: a transfer is described by its grant edge and its age in edges.
    bit              m_active = 0;
    int              m_idx = 0, m_age = 0, m_ptr = 0;
    logic            m_wrn = 1'b1;
    logic [7:0]      m_d = '0;
    logic [NREQ-1:0] m_ack = '0;
    logic            m_ack_err = 1'b0, m_err = 1'b0, m_busy = 1'b0;
    int              m_edge = 0, m_grant_edge = 0, m_ack_edge = 0, m_n_acks = 0, m_wrn_low = 0;
    int              grant_log[$];
    logic [7:0]      byte_log[$];

    // Environment state.
    int              cd = -1, resp_delay = 1, resp_kind = 0;
    bit              prev_wrn = 1'b1, force_te0 = 0, rand_en = 0, rereq = 0;
    logic [NREQ-1:0] pend = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_xfer(input bit timed_out);
        m_ack            = '0;
        m_ack[m_idx]     = 1'b1;
        m_ack_err        = timed_out;
        if (timed_out) m_err = 1'b1;
        m_ptr            = (m_idx + 1) % NREQ;
        m_active         = 0;
        m_ack_edge       = m_edge;
        m_n_acks++;
    endtask

    // Advance the model by one rising edge using the inputs the DUT just sampled.
    task automatic model_step();
        logic [NREQ-1:0] prev_ack;
        m_edge++;
        prev_ack  = m_ack;
        m_ack     = '0;
        m_ack_err = 1'b0;
        if (clr) begin
            m_active = 0; m_ptr = 0; m_wrn = 1'b1; m_d = '0; m_err = 1'b0;
        end else if (m_active) begin
            m_age++;
            if (m_age < int'(WR_LEN)) begin
                m_wrn = 1'b0;
            end else if (m_age == int'(WR_LEN)) begin
                m_wrn = 1'b1;
            end else if (!uart_t_empty || uart_sending) begin
                finish_xfer(1'b0);
            end else if (m_age - int'(WR_LEN) == int'(TIMEOUT)) begin
                finish_xfer(1'b1);
            end
        end else if (prev_ack == '0 && uart_t_empty && req != '0) begin
            for (int k = 0; k < int'(NREQ); k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (!m_active && req[j]) begin
                    m_active = 1;
                    m_idx    = j;
                end
            end
            m_d          = req_data[8*m_idx +: 8];
            m_age        = 0;
            m_wrn        = 1'b0;
            m_grant_edge = m_edge;
            grant_log.push_back(m_idx);
            byte_log.push_back(m_d);
        end
        m_busy = m_active;
        if (m_wrn == 1'b0) m_wrn_low++;
    endtask

    // UART stand-in: after wrn rises, signal "taken" via sending or t_empty, or never.
    task automatic uart_resp();
        uart_sending = 1'b0;
        uart_t_empty = !force_te0;
        if (rand_en && $urandom_range(0, 15) == 0) uart_t_empty = 1'b0;
        if (!prev_wrn && uart_wrn === 1'b1) begin
            if (rand_en) begin
                resp_kind  = ($urandom_range(0, 15) == 0) ? 2 : int'($urandom_range(0, 1));
                resp_delay = int'($urandom_range(0, 5));
            end
            cd = (resp_kind == 2) ? -1 : resp_delay;
        end
        prev_wrn = (uart_wrn === 1'b1);
        if (cd == 0) begin
            if (resp_kind == 1) uart_t_empty = 1'b0;
            else                uart_sending = 1'b1;
            cd = -1;
        end else if (cd > 0) begin
            cd--;
        end
    endtask

    task automatic requesters();
        for (int i = 0; i < int'(NREQ); i++) begin
            if (clr) begin
                req[i]  = 1'b0;
                pend[i] = 1'b0;
            end else if (m_ack[i]) begin
                req[i]  = 1'b0;
                pend[i] = rereq;
            end else if (pend[i]) begin
                req[i]  = 1'b1;
                pend[i] = 1'b0;
            end else if (rand_en && !req[i] && $urandom_range(0, 7) == 0) begin
                req[i]            = 1'b1;
                req_data[8*i +: 8] = 8'($urandom);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk16x);
        #1;
        model_step();
        uart_resp();
        requesters();
    endtask

    task automatic wait_acks(input int n, input int budget, input string name);
        int target, t;
        target = m_n_acks + n;
        t      = 0;
        while (m_n_acks < target && t < budget) begin
            tick();
            t++;
        end
        n_tests++;
        if (m_n_acks < target) begin
            n_fail++;
            $display("FAIL %s: only %0d of %0d acks within %0d cycles", name,
                     m_n_acks - target + n, n, budget);
        end
    endtask

    task automatic wait_grant(input int budget, input string name);
        int t;
        t = 0;
        while (!m_active && t < budget) begin
            tick();
            t++;
        end
        n_tests++;
        if (!m_active) begin
            n_fail++;
            $display("FAIL %s: no grant within %0d cycles", name, budget);
        end
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while ((req != '0 || m_active) && t < budget) begin
            tick();
            t++;
        end
        n_tests++;
        if (req != '0 || m_active) begin
            n_fail++;
            $display("FAIL drain: requests still pending after %0d cycles", budget);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk16x) begin
        if (chk_en) begin
            check("uart_wrn",   32'(uart_wrn),   32'(m_wrn));
            check("uart_d_in",  32'(uart_d_in),  32'(m_d));
            check("ack",        32'(ack),        32'(m_ack));
            check("ack_err",    32'(ack_err),    32'(m_ack_err));
            check("busy",       32'(busy),       32'(m_busy));
            check("err_sticky", 32'(err_sticky), 32'(m_err));
            check("ack_onehot", 32'($onehot0(ack)), 32'd1);
        end
    end

    initial begin
        int         s, a;
        bit         seen_ack;
        int         exp_g[5];
        logic [7:0] exp_b[5];

        clr = 1'b1; req = '0; req_data = '0; uart_t_empty = 1'b1; uart_sending = 1'b0;
        tick();
        chk_en = 1;
        tick();
        check("rst_wrn",  32'(uart_wrn),   32'd1);
        check("rst_d_in", 32'(uart_d_in),  32'd0);
        check("rst_ack",  32'(ack),        32'd0);
        check("rst_busy", 32'(busy),       32'd0);
        check("rst_err",  32'(err_sticky), 32'd0);
        clr = 1'b0;

        // Single request, UART takes the byte one cycle after wrn rises.
        resp_kind = 0; resp_delay = 1; m_wrn_low = 0;
        req_data[7:0] = 8'hA5; req = 4'b0001;
        wait_acks(1, 50, "t1_ack");
        check("t1_ack_val", 32'(ack),                    32'h1);
        check("t1_ack_err", 32'(ack_err),                32'd0);
        check("t1_busy",    32'(busy),                   32'd0);
        check("t1_latency", 32'(m_ack_edge - m_grant_edge), 32'd4);
        check("t1_wrn_low", 32'(m_wrn_low),              32'd2);
        check("t1_byte",    32'(byte_log[byte_log.size()-1]), 32'hA5);

        // All four requesting: rotation 0,1,2,3,0.
        clr = 1'b1; tick(); clr = 1'b0;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        rereq = 1; req = 4'b1111;
        s = grant_log.size();
        wait_acks(5, 200, "t2_acks");
        exp_g = '{0, 1, 2, 3, 0};
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        for (int k = 0; k < 5; k++) begin
            check("t2_grant", 32'(grant_log[s+k]), 32'(exp_g[k]));
            check("t2_byte",  32'(byte_log[s+k]),  32'(exp_b[k]));
        end
        rereq = 0; pend = '0;
        drain(300);

        // UART busy: no grant while t_empty is low.
        force_te0 = 1; uart_t_empty = 1'b0; req = 4'b0010;
        s = grant_log.size();
        repeat (20) tick();
        check("t3_no_grant", 32'(grant_log.size() - s), 32'd0);
        check("t3_busy",     32'(busy),     32'd0);
        check("t3_wrn",      32'(uart_wrn), 32'd1);
        force_te0 = 0;
        wait_acks(1, 50, "t3_ack");
        check("t3_grant", 32'(grant_log[s]), 32'd1);

        // UART never responds: timeout ack with error, sticky flag survives good transfer.
        resp_kind = 2; req_data[23:16] = 8'h77; req = 4'b0100;
        wait_acks(1, 120, "t4_ack");
        check("t4_ack_err",  32'(ack_err),    32'd1);
        check("t4_sticky",   32'(err_sticky), 32'd1);
        check("t4_latency",  32'(m_ack_edge - m_grant_edge), 32'(WR_LEN + TIMEOUT));
        resp_kind = 0; req = 4'b0001;
        wait_acks(1, 50, "t4_good");
        check("t4_good_err",   32'(ack_err),    32'd0);
        check("t4_sticky_kept", 32'(err_sticky), 32'd1);

        // clr during WRITE discards the transfer and resets the pointer.
        req = 4'b0010;
        wait_acks(1, 50, "t5_pre");
        req = 4'b0100;
        wait_grant(20, "t5_grant");
        clr = 1'b1; tick(); clr = 1'b0;
        check("t5_wrn",  32'(uart_wrn), 32'd1);
        check("t5_busy", 32'(busy),     32'd0);
        seen_ack = 0;
        a = m_n_acks;
        repeat (5) begin
            tick();
            seen_ack = seen_ack | (|ack);
        end
        check("t5_no_ack", 32'(seen_ack), 32'd0);
        req = 4'b1000;
        wait_acks(1, 50, "t5_ack");
        check("t5_grant3", 32'(grant_log[grant_log.size()-1]), 32'd3);
        check("t5_ack3",   32'(ack), 32'h8);

        // Requester drops req and changes data after grant.
        req_data[23:16] = 8'h5A; req = 4'b0100;
        wait_grant(20, "t6_grant");
        tick();
        req[2] = 1'b0; req_data[23:16] = 8'hFF;
        wait_acks(1, 50, "t6_ack");
        check("t6_ack2",  32'(ack),       32'h4);
        check("t6_d_in",  32'(uart_d_in), 32'h5A);
        check("t6_byte",  32'(byte_log[byte_log.size()-1]), 32'h5A);

        // Randomized traffic with a randomly behaving UART.
        rand_en = 1;
        for (int c = 0; c < 4000; c++) begin
            clr = ($urandom_range(0, 999) == 0);
            tick();
        end
        clr = 1'b0; rand_en = 0; resp_kind = 0; resp_delay = 1; force_te0 = 0;
        drain(1000);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
